// File: rtl/saniye_sayac_pkg.sv
// saniye_sayac_pkg
// Shared constants and helpers for the seconds counter and its button
// debouncers.
//   SANIYE_W         : width of the seconds value
//   SANIYE_MAX       : last legal seconds value before wrapping to 0
//   DEF_CLK_HZ       : default clock cycles per one-second tick
//   DEF_DEBOUNCE_CYC : default cycles a button must be stable to be accepted
//   saniye_inc/dec   : wrap-around seconds arithmetic
package saniye_sayac_pkg;

  localparam int SANIYE_W = 6;
  localparam logic [SANIYE_W-1:0] SANIYE_MAX = 6'd59;
  localparam int DEF_CLK_HZ = 100_000_000;
  localparam int DEF_DEBOUNCE_CYC = 1_000_000;

  // Anything at or above the top value wraps to 0, so an out-of-range value
  // can never propagate further.
  function automatic logic [SANIYE_W-1:0] saniye_inc(input logic [SANIYE_W-1:0] v);
    return (v >= SANIYE_MAX) ? '0 : v + SANIYE_W'(1);
  endfunction

  // Zero borrows around to the top value; out-of-range values snap back to it.
  function automatic logic [SANIYE_W-1:0] saniye_dec(input logic [SANIYE_W-1:0] v);
    logic [SANIYE_W-1:0] r;
    if (v == '0 || v > SANIYE_MAX) r = SANIYE_MAX;
    else r = v - SANIYE_W'(1);
    return r;
  endfunction

endpackage

// File: rtl/buton_debounce.sv
// buton_debounce
// Turns a raw asynchronous push-button into a single-cycle request pulse.
//   i_clk   : system clock
//   i_rst_n : asynchronous active-low reset
//   i_btn   : raw button level, asynchronous to i_clk
//   o_rise  : registered one-cycle pulse on each accepted press
module buton_debounce
  import saniye_sayac_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_rise
);

  localparam int CW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_clean;
  logic          r_rise;
  logic [CW-1:0] r_cnt;

  // Two-flop synchronizer brings the raw level into the clock domain.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
    end
  end

  // The counter tracks how many consecutive samples disagree with the clean
  // level; any agreeing sample restarts it, so only a stable change is taken.
  // The press pulse is produced at the moment the clean level goes high,
  // which makes holding the button a single request.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_clean <= 1'b0;
      r_cnt   <= '0;
      r_rise  <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      if (r_sync2 == r_clean) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_clean <= r_sync2;
        r_cnt   <= '0;
        r_rise  <= r_sync2;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_rise = r_rise;

endmodule

// File: rtl/saniye_sayac.sv
// saniye_sayac
// Seconds counter 0..59 driven by a clock prescaler, with manual adjust
// buttons usable while counting is stopped.
//   clk           : system clock
//   reset         : asynchronous active-low reset
//   stop          : high freezes counting and enables manual adjust
//   arttir_buton  : raw increment button
//   azalt_buton   : raw decrement button
//   saniye        : current seconds value (registered)
//   dakika_arttir : one-cycle carry to the minute counter on 59 -> 0
//   tik           : one-cycle pulse after each prescaler terminal count
module saniye_sayac
  import saniye_sayac_pkg::*;
#(
  parameter int CLK_HZ       = DEF_CLK_HZ,
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stop,
  input  logic                arttir_buton,
  input  logic                azalt_buton,
  output logic [SANIYE_W-1:0] saniye,
  output logic                dakika_arttir,
  output logic                tik
);

  localparam int PW = $clog2(CLK_HZ);
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);

  logic                w_arttir_req;
  logic                w_azalt_req;
  logic [PW-1:0]       r_presc;
  logic [SANIYE_W-1:0] r_saniye;
  logic                r_dakika;
  logic                r_tik;

  buton_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_arttir (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_btn   (arttir_buton),
    .o_rise  (w_arttir_req)
  );

  buton_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_azalt (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_btn   (azalt_buton),
    .o_rise  (w_azalt_req)
  );

  // Stop has priority over the prescaler: it parks the prescaler at 0 so the
  // next tick comes a full second after stop falls, and it is the only time
  // button requests are honoured. A request pulse that lands while running is
  // simply dropped. Simultaneous requests cancel each other.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_presc  <= '0;
      r_saniye <= '0;
      r_dakika <= 1'b0;
      r_tik    <= 1'b0;
    end else if (stop) begin
      r_presc  <= '0;
      r_tik    <= 1'b0;
      r_dakika <= 1'b0;
      if (w_arttir_req && !w_azalt_req) begin
        r_saniye <= saniye_inc(r_saniye);
      end else if (w_azalt_req && !w_arttir_req) begin
        r_saniye <= saniye_dec(r_saniye);
      end
    end else if (r_presc == PRESC_LAST) begin
      r_presc  <= '0;
      r_tik    <= 1'b1;
      r_dakika <= (r_saniye >= SANIYE_MAX);
      r_saniye <= saniye_inc(r_saniye);
    end else begin
      r_presc  <= r_presc + PW'(1);
      r_tik    <= 1'b0;
      r_dakika <= 1'b0;
    end
  end

  assign saniye        = r_saniye;
  assign dakika_arttir = r_dakika;
  assign tik           = r_tik;

endmodule

// File: tb/tb_saniye_sayac.sv
// tb_saniye_sayac
// Self-checking bench for saniye_sayac with CLK_HZ=10, DEBOUNCE_CYC=4.
// Expected values come from elapsed-cycle arithmetic and a modulo-60
// seconds model.
module tb_saniye_sayac;

  localparam int CLK_HZ = 10;
  localparam int DEB    = 4;

  logic       clk    = 1'b0;
  logic       reset  = 1'b0;
  logic       stop   = 1'b0;
  logic       arttir = 1'b0;
  logic       azalt  = 1'b0;
  logic [5:0] saniye;
  logic       dakika;
  logic       tik;

  int checks = 0;
  int errors = 0;
  int refSaniye = 0;

  saniye_sayac #(.CLK_HZ(CLK_HZ), .DEBOUNCE_CYC(DEB)) dut (
    .clk           (clk),
    .reset         (reset),
    .stop          (stop),
    .arttir_buton  (arttir),
    .azalt_buton   (azalt),
    .saniye        (saniye),
    .dakika_arttir (dakika),
    .tik           (tik)
  );

  always #5 clk = ~clk;

  // Advance one clock edge and settle just past it.
  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Hold reset for a few cycles, then release it just after a rising edge.
  task automatic doReset(input bit stopVal);
    reset  = 1'b0;
    stop   = stopVal;
    arttir = 1'b0;
    azalt  = 1'b0;
    repeat (3) stepCycle();
    reset = 1'b1;
  endtask

  // Drive a button pattern and report whether tik or dakika appeared.
  task automatic press(input bit inc, input bit dec, input int len, input int gap,
                       output bit saw);
    saw    = 1'b0;
    arttir = inc;
    azalt  = dec;
    repeat (len) begin
      stepCycle();
      if (dakika || tik) saw = 1'b1;
    end
    arttir = 1'b0;
    azalt  = 1'b0;
    repeat (gap) begin
      stepCycle();
      if (dakika || tik) saw = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) stepCycle();
    checks++;
    if (saniye !== 6'd0) begin
      errors++;
      $display("[TB] FAIL reset_saniye: got %0d expected 0", saniye);
    end
    checks++;
    if (tik !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_tik: got %0b expected 0", tik);
    end
    checks++;
    if (dakika !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_dakika: got %0b expected 0", dakika);
    end
  endtask

  // Free run for a full minute: tick every CLK_HZ cycles, one carry at the end.
  task automatic test_count();
    int expSan;
    bit expTik;
    bit expDak;
    doReset(1'b0);
    for (int k = 1; k <= 600; k++) begin
      stepCycle();
      expTik = (k % CLK_HZ == 0);
      expSan = (k / CLK_HZ) % 60;
      expDak = (k % (60 * CLK_HZ) == 0);
      checks++;
      if (tik !== expTik) begin
        errors++;
        $display("[TB] FAIL count_tik k=%0d: got %0b expected %0b", k, tik, expTik);
      end
      checks++;
      if (saniye !== 6'(expSan)) begin
        errors++;
        $display("[TB] FAIL count_saniye k=%0d: got %0d expected %0d", k, saniye, expSan);
      end
      checks++;
      if (dakika !== expDak) begin
        errors++;
        $display("[TB] FAIL count_dakika k=%0d: got %0b expected %0b", k, dakika, expDak);
      end
    end
  endtask

  task automatic test_stop_adjust();
    bit saw;
    doReset(1'b0);
    repeat (59 * CLK_HZ) stepCycle();
    stop = 1'b1;
    refSaniye = 59;
    checks++;
    if (saniye !== 6'(refSaniye)) begin
      errors++;
      $display("[TB] FAIL adjust_start: got %0d expected %0d", saniye, refSaniye);
    end
    press(1'b1, 1'b0, 8, 12, saw);
    refSaniye = (refSaniye + 1) % 60;
    checks++;
    if (saniye !== 6'(refSaniye)) begin
      errors++;
      $display("[TB] FAIL adjust_inc_wrap: got %0d expected %0d", saniye, refSaniye);
    end
    checks++;
    if (saw !== 1'b0) begin
      errors++;
      $display("[TB] FAIL adjust_inc_no_pulse: got %0b expected 0", saw);
    end
    press(1'b0, 1'b1, 8, 12, saw);
    refSaniye = (refSaniye + 59) % 60;
    checks++;
    if (saniye !== 6'(refSaniye)) begin
      errors++;
      $display("[TB] FAIL adjust_dec_wrap: got %0d expected %0d", saniye, refSaniye);
    end
    checks++;
    if (saw !== 1'b0) begin
      errors++;
      $display("[TB] FAIL adjust_dec_no_pulse: got %0b expected 0", saw);
    end
  endtask

  task automatic test_glitch();
    bit saw;
    press(1'b1, 1'b0, 3, 12, saw);
    checks++;
    if (saniye !== 6'(refSaniye)) begin
      errors++;
      $display("[TB] FAIL glitch_ignored: got %0d expected %0d", saniye, refSaniye);
    end
    press(1'b1, 1'b0, 20, 12, saw);
    refSaniye = (refSaniye + 1) % 60;
    checks++;
    if (saniye !== 6'(refSaniye)) begin
      errors++;
      $display("[TB] FAIL hold_single_inc: got %0d expected %0d", saniye, refSaniye);
    end
  endtask

  task automatic test_both_and_running();
    bit saw;
    press(1'b1, 1'b1, 10, 12, saw);
    checks++;
    if (saniye !== 6'(refSaniye)) begin
      errors++;
      $display("[TB] FAIL both_ignored: got %0d expected %0d", saniye, refSaniye);
    end
    stop = 1'b0;
    for (int k = 1; k <= 3 * CLK_HZ; k++) begin
      if (k == 2) arttir = 1'b1;
      if (k == 12) arttir = 1'b0;
      stepCycle();
    end
    stop = 1'b1;
    refSaniye = (refSaniye + 3) % 60;
    checks++;
    if (saniye !== 6'(refSaniye)) begin
      errors++;
      $display("[TB] FAIL running_press_dropped: got %0d expected %0d", saniye, refSaniye);
    end
    repeat (12) stepCycle();
    checks++;
    if (saniye !== 6'(refSaniye)) begin
      errors++;
      $display("[TB] FAIL running_press_not_queued: got %0d expected %0d", saniye, refSaniye);
    end
  endtask

  task automatic test_reset_midcount();
    bit expTik;
    doReset(1'b0);
    repeat (60 * CLK_HZ - 1) stepCycle();
    checks++;
    if (saniye !== 6'd59) begin
      errors++;
      $display("[TB] FAIL midreset_pre: got %0d expected 59", saniye);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (saniye !== 6'd0) begin
      errors++;
      $display("[TB] FAIL midreset_async: got %0d expected 0", saniye);
    end
    repeat (2) stepCycle();
    reset = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      stepCycle();
      expTik = (k == CLK_HZ);
      checks++;
      if (tik !== expTik) begin
        errors++;
        $display("[TB] FAIL midreset_tik k=%0d: got %0b expected %0b", k, tik, expTik);
      end
      checks++;
      if (dakika !== 1'b0) begin
        errors++;
        $display("[TB] FAIL midreset_dakika k=%0d: got %0b expected 0", k, dakika);
      end
      checks++;
      if (saniye !== 6'(k >= CLK_HZ ? 1 : 0)) begin
        errors++;
        $display("[TB] FAIL midreset_saniye k=%0d: got %0d expected %0d", k, saniye,
                 (k >= CLK_HZ ? 1 : 0));
      end
    end
  endtask

  task automatic test_reset_debounce();
    doReset(1'b1);
    arttir = 1'b1;
    repeat (5) stepCycle();
    reset = 1'b0;
    #2;
    arttir = 1'b0;
    stepCycle();
    reset = 1'b1;
    repeat (15) stepCycle();
    checks++;
    if (saniye !== 6'd0) begin
      errors++;
      $display("[TB] FAIL debounce_reset_abandon: got %0d expected 0", saniye);
    end
  endtask

  task automatic test_stop_tc();
    bit expTik;
    doReset(1'b0);
    repeat (CLK_HZ - 1) stepCycle();
    stop = 1'b1;
    stepCycle();
    checks++;
    if (tik !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stop_tc_tik: got %0b expected 0", tik);
    end
    checks++;
    if (saniye !== 6'd0) begin
      errors++;
      $display("[TB] FAIL stop_tc_saniye: got %0d expected 0", saniye);
    end
    repeat (5) stepCycle();
    stop = 1'b0;
    for (int k = 1; k <= CLK_HZ; k++) begin
      stepCycle();
      expTik = (k == CLK_HZ);
      checks++;
      if (tik !== expTik) begin
        errors++;
        $display("[TB] FAIL stop_release_tik k=%0d: got %0b expected %0b", k, tik, expTik);
      end
    end
    checks++;
    if (saniye !== 6'd1) begin
      errors++;
      $display("[TB] FAIL stop_release_saniye: got %0d expected 1", saniye);
    end
  endtask

  // Random mix of presses, glitches and double presses against the modulo model.
  task automatic test_random_adjust();
    bit saw;
    int op;
    int len;
    doReset(1'b1);
    refSaniye = 0;
    for (int n = 0; n < 30; n++) begin
      op = int'($urandom_range(0, 3));
      case (op)
        0: begin
          len = int'($urandom_range(DEB, 15));
          press(1'b1, 1'b0, len, 12, saw);
          refSaniye = (refSaniye + 1) % 60;
        end
        1: begin
          len = int'($urandom_range(DEB, 15));
          press(1'b0, 1'b1, len, 12, saw);
          refSaniye = (refSaniye + 59) % 60;
        end
        2: begin
          len = int'($urandom_range(1, DEB - 1));
          if ($urandom_range(0, 1) == 0) press(1'b1, 1'b0, len, 12, saw);
          else press(1'b0, 1'b1, len, 12, saw);
        end
        default: begin
          len = int'($urandom_range(DEB, 15));
          press(1'b1, 1'b1, len, 12, saw);
        end
      endcase
      checks++;
      if (saniye !== 6'(refSaniye)) begin
        errors++;
        $display("[TB] FAIL random_op%0d n=%0d: got %0d expected %0d", op, n, saniye, refSaniye);
      end
      checks++;
      if (saw !== 1'b0) begin
        errors++;
        $display("[TB] FAIL random_pulse n=%0d: got %0b expected 0", n, saw);
      end
    end
  endtask

  initial begin
    test_reset();
    test_count();
    test_stop_adjust();
    test_glitch();
    test_both_and_running();
    test_reset_midcount();
    test_reset_debounce();
    test_stop_tc();
    test_random_adjust();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
